// File: rtl/memcell_array.sv
// memcell_array
//   Single-port word array: DEPTH words of WIDTH bits behind one shared
//   op/sel/addr port. Reads are registered (data and a one-cycle valid strobe
//   appear the cycle after the request). A clear engine sweeps every word to
//   zero, one word per cycle, while busy is high.
//
// Ports
//   clk    system clock, all state updates on the rising edge
//   rst    synchronous, active-high reset
//   sel    access enable (1 = perform op this cycle)
//   op     0 = write, 1 = read
//   addr   word address
//   inp    write data
//   clr    one-cycle request to start a clear sweep
//   outp   registered read data, holds the last read value
//   valid  high for exactly one cycle after each accepted read
//   busy   high while the clear sweep runs
module memcell_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  inp,
    input  logic              clr,
    output logic [WIDTH-1:0]  outp,
    output logic              valid,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // DEPTH may equal 2**ADDR_W, so the range check needs one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic in_range;
    logic access;
    logic wr_en;
    logic rd_en;
    logic sweep_done;

    assign in_range   = ({1'b0, addr} < DEPTH_W);
    // clr has priority over sel; any access is only honoured from IDLE.
    assign access     = (state == IDLE) && !clr && sel;
    assign wr_en      = access && !op && in_range;
    assign rd_en      = access && op;
    assign sweep_done = (cnt == LAST_IDX);
    assign busy       = (state == CLEAR);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr) state_nxt = CLEAR;
            CLEAR:   if (sweep_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            outp  <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= rd_en;
            if (rd_en) begin
                // Out-of-range reads return zero but still strobe valid.
                outp <= in_range ? mem[addr] : '0;
            end
            if (busy) begin
                cnt <= sweep_done ? '0 : cnt + ADDR_W'(1);
            end
        end
    end

    // One register per word, each with its own enable, so the sweep and the
    // port write never drive the same storage from two processes.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [WIDTH-1:0] word;

        // NOTE: the storage is cleared by reset because reset must leave every
        // word reading zero; this costs a reset net on every word flop.
        always_ff @(posedge clk) begin
            if (rst) begin
                word <= '0;
            end else if (busy && cnt == ADDR_W'(g)) begin
                word <= '0;
            end else if (wr_en && addr == ADDR_W'(g)) begin
                word <= inp;
            end
        end

        assign mem[g] = word;
    end

endmodule

// File: tb/tb_memcell_array.sv
// tb_memcell_array
//   Directed bench for memcell_array: a default 8x8 instance and a 16-bit,
//   5-word instance share clock and reset. Read expectations are queued when
//   a read is issued and popped when the registered data appears.
module tb_memcell_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance (WIDTH=8, DEPTH=8, ADDR_W=3)
    logic       sel, op, clr;
    logic [2:0] addr;
    logic [7:0] inp;
    logic [7:0] outp;
    logic       valid, busy;

    // Wide, non-power-of-two instance (WIDTH=16, DEPTH=5, ADDR_W=3)
    logic        sel16, op16, clr16;
    logic [2:0]  addr16;
    logic [15:0] inp16;
    logic [15:0] outp16;
    logic        valid16, busy16;

    memcell_array dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .op    (op),
        .addr  (addr),
        .inp   (inp),
        .clr   (clr),
        .outp  (outp),
        .valid (valid),
        .busy  (busy)
    );

    memcell_array #(.WIDTH(16), .DEPTH(5), .ADDR_W(3)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel16),
        .op    (op16),
        .addr  (addr16),
        .inp   (inp16),
        .clr   (clr16),
        .outp  (outp16),
        .valid (valid16),
        .busy  (busy16)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge, outputs are sampled at the next one.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, got, sb_q.pop_front());
        end
    endtask

    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        sel = 1'b1; op = 1'b0; addr = a; inp = d; clr = 1'b0;
        tick();
        sel = 1'b0;
    endtask

    task automatic rd8(input logic [2:0] a, input logic [7:0] exp);
        sb_q.push_back({24'd0, exp});
        sel = 1'b1; op = 1'b1; addr = a; clr = 1'b0;
        tick();
        sel = 1'b0;
        pop_check("rd8 data", {24'd0, outp});
        check("rd8 valid", {31'd0, valid}, 32'd1);
    endtask

    task automatic wr16(input logic [2:0] a, input logic [15:0] d);
        sel16 = 1'b1; op16 = 1'b0; addr16 = a; inp16 = d; clr16 = 1'b0;
        tick();
        sel16 = 1'b0;
    endtask

    task automatic rd16(input logic [2:0] a, input logic [15:0] exp);
        sb_q.push_back({16'd0, exp});
        sel16 = 1'b1; op16 = 1'b1; addr16 = a; clr16 = 1'b0;
        tick();
        sel16 = 1'b0;
        pop_check("rd16 data", {16'd0, outp16});
        check("rd16 valid", {31'd0, valid16}, 32'd1);
    endtask

    // Counts busy cycles of the 8-bit instance while hammering the port with
    // reads and repeat clr requests that must all be ignored.
    task automatic sweep8(input int len, input logic [7:0] hold);
        int n = 0;
        sel = 1'b1; op = 1'b1; addr = 3'd1; clr = 1'b1;
        while (busy === 1'b1 && n < 2 * len + 4) begin
            check("clr valid", {31'd0, valid}, 32'd0);
            check("clr outp", {24'd0, outp}, {24'd0, hold});
            n++;
            tick();
        end
        sel = 1'b0; clr = 1'b0;
        check("busy length", n, len);
        check("busy after sweep", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0; op = 1'b0; clr = 1'b0; addr = '0; inp = '0;
        sel16 = 1'b0; op16 = 1'b0; clr16 = 1'b0; addr16 = '0; inp16 = '0;

        // Reset state
        tick();
        rst = 1'b0;
        check("reset outp", {24'd0, outp}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset busy16", {31'd0, busy16}, 32'd0);
        rd8(3'd5, 8'h00);

        // Write three words, read them back-to-back
        wr8(3'd0, 8'hAA);
        wr8(3'd3, 8'hCC);
        wr8(3'd7, 8'hF0);
        rd8(3'd3, 8'hCC);
        rd8(3'd0, 8'hAA);
        rd8(3'd7, 8'hF0);

        // Deselect holds outp and drops valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle outp", {24'd0, outp}, 32'hF0);
            check("idle valid", {31'd0, valid}, 32'd0);
        end
        wr8(3'd7, 8'h55);
        check("write keeps outp", {24'd0, outp}, 32'hF0);
        check("write valid", {31'd0, valid}, 32'd0);
        rd8(3'd7, 8'h55);

        // Clear sweep with a colliding write in the request cycle
        for (int i = 0; i < 8; i++) wr8(3'(i), 8'hFF);
        sel = 1'b1; op = 1'b0; addr = 3'd2; inp = 8'h11; clr = 1'b1;
        tick();
        sweep8(8, 8'h55);
        for (int i = 0; i < 8; i++) rd8(3'(i), 8'h00);

        // Reset in the middle of a sweep
        for (int i = 0; i < 8; i++) wr8(3'(i), 8'hFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mid busy", {31'd0, busy}, 32'd1);
            if (i < 3) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid outp", {24'd0, outp}, 32'd0);
        check("rst mid valid", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 8; i++) rd8(3'(i), 8'h00);
        wr8(3'd6, 8'h3C);
        rd8(3'd6, 8'h3C);

        // Wide, five-word instance
        wr16(3'd4, 16'hBEEF);
        rd16(3'd4, 16'hBEEF);
        wr16(3'd6, 16'h1234);
        rd16(3'd6, 16'h0000);
        rd16(3'd4, 16'hBEEF);
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        begin
            int n = 0;
            while (busy16 === 1'b1 && n < 20) begin
                check("clr16 valid", {31'd0, valid16}, 32'd0);
                n++;
                tick();
            end
            check("busy16 length", n, 5);
        end
        rd16(3'd4, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memcell_array.md
Name: memcell_array

Overview:
- Parametrised, clocked successor to the 8-bit bytecell: an array of DEPTH words of WIDTH bits behind one shared op/sel/addr port.
- Single-port storage with registered read data and a one-cycle read-valid strobe.
- Built-in clear engine sweeps every word to zero, one word per cycle.
- Forms the storage core of the mem8x8 memory and its wider/deeper variants.

Parameters:
WIDTH, 8, bits per word
DEPTH, 8, number of words (1..2**ADDR_W; need not be a power of two)
ADDR_W, 3, address width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
sel  input  1  access enable; 1 = perform op this cycle
op  input  1  0 = write, 1 = read (same encoding as bytecell)
addr  input  ADDR_W  word address
inp  input  WIDTH  write data
clr  input  1  1-cycle request to start a clear sweep
outp  output  WIDTH  registered read data; holds last read value
valid  output  1  1 for exactly one cycle after each accepted read
busy  output  1  1 while the clear sweep runs

Behaviour:
- Reset (rst=1 at clk edge):
  - All DEPTH words <= 0; outp <= 0, valid <= 0, busy <= 0.
  - State <= IDLE, sweep counter <= 0.
  - Reset wins over every other input, including mid-sweep.
- States: IDLE, CLEAR.
- IDLE, priority order clr > sel:
  - clr=1: enter CLEAR. No access is performed that cycle even if sel=1. busy=1 from the next cycle.
  - sel=1, op=0: mem[addr] <= inp at this edge. valid <= 0, outp unchanged.
  - sel=1, op=1: outp <= mem[addr] at this edge, valid <= 1. Latency: data on outp and valid=1 in the cycle after the request.
  - sel=0: no change to memory or outp; valid <= 0.
- Back-to-back reads:
  - valid stays 1 while reads continue every cycle.
  - outp updates every cycle.
- Write then read of the same addr on consecutive cycles: the read returns the newly written value.
- Out-of-range addr (addr >= DEPTH):
  - Write is dropped; memory unchanged.
  - Read gives outp <= 0, valid <= 1.
- CLEAR:
  - Each cycle mem[cnt] <= 0, then cnt <= cnt+1.
  - After the word at cnt = DEPTH-1 is cleared: cnt <= 0, state <= IDLE, busy <= 0.
  - busy is 1 for exactly DEPTH cycles.
- During CLEAR:
  - sel, op, addr, inp and clr are ignored; no write, no read.
  - valid = 0; outp holds its pre-clear value. The sweep does not touch outp.
- First access after CLEAR: accepted in the cycle busy reads 0.
- DEPTH=1: the sweep lasts 1 cycle.
- Memory contents are not defined before the first reset.

Test Plan:
- Reset, then idle: after rst=1 for 1 cycle -> outp=0x00, valid=0, busy=0; read addr 5 -> outp=0x00, valid=1 next cycle.
- Write/read: write 0xAA@0, 0xCC@3, 0xF0@7 (op=0, sel=1), then read 3, 0, 7 back-to-back -> outp 0xCC, 0xAA, 0xF0 on consecutive cycles, valid held 1 for 3 cycles then 0.
- Hold/deselect:
  - After reading 0xF0, sel=0 for 3 cycles -> outp stays 0xF0, valid=0.
  - sel=1, op=0, inp=0x55@7 -> outp still 0xF0.
  - Then read 7 -> 0x55.
- Clear sweep:
  - Fill all 8 words with 0xFF, pulse clr with sel=1, op=0, inp=0x11, addr=2 in the same cycle.
  - Required: busy=1 for exactly 8 cycles, the sel write is dropped, outp unchanged.
  - Reading addrs 0..7 afterwards returns 0x00 each.
- Reset mid-clear: fill 0xFF, pulse clr, assert rst on the 4th busy cycle -> busy=0 the next cycle and every word reads 0x00; a write/read of 0x3C@6 then works normally.
- Parametrised instance WIDTH=16, DEPTH=5, ADDR_W=3:
  - Write 0xBEEF@4 -> reads back 0xBEEF.
  - Write 0x1234@6 is dropped; read 6 -> 0x0000 with valid=1.
  - clr -> busy=1 for exactly 5 cycles.
